// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-requester data-memory arbiter: the access
// FSM state encoding and the default bus/memory widths.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int MEM_AW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports, their response ports and the data-memory
// port of the arbiter.
//   reqN_valid/write/address/wdata : request from requester N
//   reqN_ready                     : request accepted this cycle
//   rspN_valid/rdata/err           : one-cycle response to requester N
//   mem_address/data_in/write/read : towards the data memory
//   mem_data_out                   : combinational read data from memory
// Modports:
//   slave  : the arbiter itself
//   master : requesters plus memory model (testbench side)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              req0_valid;
    logic              req0_write;
    logic [DATA_W-1:0] req0_address;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_write;
    logic [DATA_W-1:0] req1_address;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_wdata,
        input  req1_valid, req1_write, req1_address, req1_wdata,
        input  mem_data_out,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_address, mem_data_in, mem_write, mem_read
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_wdata,
        output req1_valid, req1_write, req1_address, req1_wdata,
        output mem_data_out,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_address, mem_data_in, mem_write, mem_read
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. When both requesters are valid the one named by
// ptr_i wins; a single valid requester always wins.
//   valid_i[1:0] : requester valid bits
//   ptr_i        : requester favoured on a tie
//   grant_o[1:0] : one-hot grant (all zero when nothing is valid)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // Tie goes to the favoured requester; otherwise the valid vector is
    // already one-hot (or zero) and is the grant.
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between two requesters with round-robin
// arbitration. Each accepted request is latched, range-checked and executed
// as a one-cycle load, a store followed by a recovery cycle, or an immediate
// error response when the address lies outside the decoded memory.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : requester, response and memory signals (dmem_arbiter_if.slave)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              id_q, id_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic [1:0]        rspValid_q, rspValid_d;
    logic [1:0]        rspErr_q, rspErr_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        reqValid;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic              accept;
    logic              acceptId;
    logic [DATA_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selWrite;
    logic              selInRange;

    assign reqValid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_rr_arb2 (
        .valid_i (reqValid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Ready is only offered while idle and out of reset, so a request that
    // coincides with reset is never taken.
    assign ready    = grant & {2{(state_q == IDLE) && !rst}};
    assign accept   = |ready;
    assign acceptId = ready[1];

    assign selAddr    = acceptId ? bus.req1_address : bus.req0_address;
    assign selWdata   = acceptId ? bus.req1_wdata   : bus.req0_wdata;
    assign selWrite   = acceptId ? bus.req1_write   : bus.req0_write;
    assign selInRange = ((selAddr >> MEM_AW) == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: out-of-range requests never leave IDLE; stores take an
    // extra RECOVER cycle so the write strobe drops between two stores.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && selInRange) state_d = ACCESS;
            ACCESS:  state_d = write_q ? RECOVER : IDLE;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values. The memory strobes and responses are
    // computed one cycle ahead so they leave the block registered.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        memRead_d  = 1'b0;
        memWrite_d = 1'b0;
        rspValid_d = '0;
        rspErr_d   = '0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = selAddr;
                    wdata_d = selWdata;
                    write_d = selWrite;
                    id_d    = acceptId;
                    ptr_d   = ~acceptId;
                    if (selInRange) begin
                        memRead_d  = ~selWrite;
                        memWrite_d = selWrite;
                    end else begin
                        rspValid_d[acceptId] = 1'b1;
                        rspErr_d[acceptId]   = 1'b1;
                        if (acceptId) rdata1_d = '0;
                        else          rdata0_d = '0;
                    end
                end
            end
            ACCESS: begin
                // Load data is captured here; a store answers with zero and
                // its pulse lands in the RECOVER cycle.
                rspValid_d[id_q] = 1'b1;
                if (id_q) rdata1_d = write_q ? '0 : bus.mem_data_out;
                else      rdata0_d = write_q ? '0 : bus.mem_data_out;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            id_q       <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            rspValid_q <= '0;
            rspErr_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            id_q       <= id_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.req0_ready  = ready[0];
    assign bus.req1_ready  = ready[1];
    assign bus.rsp0_valid  = rspValid_q[0];
    assign bus.rsp1_valid  = rspValid_q[1];
    assign bus.rsp0_err    = rspErr_q[0];
    assign bus.rsp1_err    = rspErr_q[1];
    assign bus.rsp0_rdata  = rdata0_q;
    assign bus.rsp1_rdata  = rdata1_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_write   = memWrite_q;
    assign bus.mem_read    = memRead_q;

endmodule
